// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_if
// Brief    : Controller <-> datapath/memory signal bundle for multicycle_ctrl.
//            master = controller side, slave = datapath/memory side.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_we;
    logic [2:0] state;
    logic       fault;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b,
               reg_dst, mem_to_reg, reg_we, state, fault
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_b,
               reg_dst, mem_to_reg, reg_we, state, fault
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multicycle sequencing controller (FETCH/DECODE/EXEC/MEM/WB) for
//            the 16-bit datapath, with req/ack handshake to shared memory.
//            Optional memory watchdog enabled by defining CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 8
) (
    input wire                clk,
    input wire                rst_n,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] c_op_r    = 4'd0;
    localparam logic [3:0] c_op_addi = 4'd1;
    localparam logic [3:0] c_op_lw   = 4'd2;
    localparam logic [3:0] c_op_sw   = 4'd3;
    localparam logic [3:0] c_op_beq  = 4'd4;
    localparam logic [3:0] c_op_j    = 4'd5;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("multicycle_ctrl: TIMEOUT must be in 1..255");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_run;
    logic [3:0] r_op_q;
    logic       w_expire;

    // Run flag: holds the controller idle for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    // State register and opcode latch (opcode captured while in DECODE)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op_q  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_run && r_state == S_DECODE) r_op_q <= bus.opcode;
        end
    end

`ifdef CTRL_TIMEOUT_EN
    localparam logic [7:0] c_wd_last = 8'(TIMEOUT - 1);

    logic [7:0] r_wd_cnt;
    logic       w_waiting;

    // A wait cycle is a memory-request cycle without an ack; the counter holds
    // the number of earlier wait cycles, so cycle TIMEOUT without ack expires.
    assign w_waiting = r_run && !bus.mem_ack &&
                       (r_state == S_FETCH || r_state == S_MEM);
    assign w_expire  = w_waiting && (r_wd_cnt == c_wd_last);

    // Watchdog counter: counts consecutive wait cycles, zero otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_wd_cnt <= 8'd0;
        else if (w_waiting) r_wd_cnt <= r_wd_cnt + 8'd1;
        else                r_wd_cnt <= 8'd0;
    end
`else
    assign w_expire = 1'b0;
`endif

    assign bus.state = r_state;

    // Next-state and datapath control decode
    always_comb begin
        w_state_nxt    = r_state;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'd0;
        bus.alu_src_b  = 2'd0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_we     = 1'b0;
        bus.fault      = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'd1;
                    if (bus.mem_ack) begin
                        bus.ir_we   = 1'b1;
                        bus.pc_we   = 1'b1;
                        w_state_nxt = S_DECODE;
                    end else if (w_expire) begin
                        w_state_nxt = S_FAULT;
                    end
                end
                // Decode acts on the live IR opcode; op_q is valid from EXEC on
                S_DECODE: begin
                    if (bus.opcode == c_op_j) begin
                        bus.pc_src  = 2'd2;
                        bus.pc_we   = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else if (bus.opcode > c_op_j) begin
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_op_q)
                        c_op_r: begin
                            bus.alu_src_b = 2'd0;
                            w_state_nxt   = S_WB;
                        end
                        c_op_addi: begin
                            bus.alu_src_b = 2'd2;
                            w_state_nxt   = S_WB;
                        end
                        c_op_lw, c_op_sw: begin
                            bus.alu_src_b = 2'd2;
                            w_state_nxt   = S_MEM;
                        end
                        c_op_beq: begin
                            bus.alu_src_b = 2'd0;
                            bus.pc_src    = 2'd1;
                            bus.pc_we     = bus.zero;
                            w_state_nxt   = S_FETCH;
                        end
                        default: w_state_nxt = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_we  = (r_op_q == c_op_sw);
                    if (bus.mem_ack) begin
                        w_state_nxt = (r_op_q == c_op_sw) ? S_FETCH : S_WB;
                    end else if (w_expire) begin
                        w_state_nxt = S_FAULT;
                    end
                end
                S_WB: begin
                    bus.reg_we     = 1'b1;
                    bus.reg_dst    = (r_op_q == c_op_r);
                    bus.mem_to_reg = (r_op_q == c_op_lw);
                    w_state_nxt    = S_FETCH;
                end
                S_FAULT: begin
`ifdef CTRL_TIMEOUT_EN
                    bus.fault = 1'b1;
`else
                    w_state_nxt = S_FETCH;
`endif
                end
                default: w_state_nxt = S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observed output vector, same layout as ov()
    logic [15:0] obs;
    assign obs = {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we,
                  bus.pc_src, bus.alu_src_b, bus.reg_dst, bus.mem_to_reg, bus.reg_we,
                  bus.fault};

    function automatic logic [15:0] ov(input logic [2:0] st, input logic req, input logic we,
                                       input logic io, input logic irw, input logic pcw,
                                       input logic [1:0] ps, input logic [1:0] ab,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic flt);
        return {st, req, we, io, irw, pcw, ps, ab, rd, m2r, rw, flt};
    endfunction

    localparam logic [15:0] c_f_wait    = ov(3'd0, 1, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0, 0);
    localparam logic [15:0] c_f_ack     = ov(3'd0, 1, 0, 0, 1, 1, 2'd0, 2'd1, 0, 0, 0, 0);
    localparam logic [15:0] c_dec       = ov(3'd1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_dec_j     = ov(3'd1, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_ex_r      = ov(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_ex_imm    = ov(3'd2, 0, 0, 0, 0, 0, 2'd0, 2'd2, 0, 0, 0, 0);
    localparam logic [15:0] c_ex_beq_t  = ov(3'd2, 0, 0, 0, 0, 1, 2'd1, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_ex_beq_n  = ov(3'd2, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_mem_ld    = ov(3'd3, 1, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_mem_st    = ov(3'd3, 1, 1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0);
    localparam logic [15:0] c_wb_r      = ov(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0);
    localparam logic [15:0] c_wb_i      = ov(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 0);
    localparam logic [15:0] c_wb_lw     = ov(3'd4, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, 0);
    localparam logic [15:0] c_fault     = ov(3'd7, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1);

    typedef struct packed {
        logic [3:0]  op;
        logic        z;
        logic        ack;
        logic [15:0] e;
    } row_t;

    // Reset and the idle cycle right after release
    task automatic test_reset();
        rst_n = 1'b0; bus.opcode = 4'd0; bus.zero = 1'b0; bus.mem_ack = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        n_tests++;
        if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, 16'h0); end
        @(negedge clk); rst_n = 1'b1; #1;
        n_tests++;
        if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, 16'h0); end
        @(negedge clk); bus.mem_ack = 1'b0; #1;
        n_tests++;
        if (obs !== c_f_wait) begin n_fail++; $display("FAIL reset_first_req: got %h expected %h", obs, c_f_wait); end
    endtask

    // R-type, zero-wait; opcode changed after DECODE to prove op_q is used
    task automatic test_rtype();
        row_t t[5];
        t = '{'{4'd0, 1'b0, 1'b1, c_f_ack}, '{4'd0, 1'b0, 1'b0, c_dec},
              '{4'd15, 1'b0, 1'b0, c_ex_r}, '{4'd15, 1'b0, 1'b0, c_wb_r},
              '{4'd0, 1'b0, 1'b0, c_f_wait}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL rtype[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 4) @(negedge clk);
        end
    endtask

    task automatic test_addi();
        row_t t[5];
        t = '{'{4'd1, 1'b0, 1'b1, c_f_ack}, '{4'd1, 1'b0, 1'b0, c_dec},
              '{4'd0, 1'b0, 1'b0, c_ex_imm}, '{4'd0, 1'b0, 1'b0, c_wb_i},
              '{4'd1, 1'b0, 1'b0, c_f_wait}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL addi[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 4) @(negedge clk);
        end
    endtask

    // LW with three memory wait cycles: 8 cycles FETCH..WB
    task automatic test_lw_wait();
        row_t t[9];
        t = '{'{4'd2, 1'b0, 1'b1, c_f_ack}, '{4'd2, 1'b0, 1'b0, c_dec},
              '{4'd3, 1'b0, 1'b0, c_ex_imm}, '{4'd3, 1'b0, 1'b0, c_mem_ld},
              '{4'd3, 1'b0, 1'b0, c_mem_ld}, '{4'd3, 1'b0, 1'b0, c_mem_ld},
              '{4'd3, 1'b0, 1'b1, c_mem_ld}, '{4'd3, 1'b0, 1'b0, c_wb_lw},
              '{4'd2, 1'b0, 1'b0, c_f_wait}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL lw_wait[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 8) @(negedge clk);
        end
    endtask

    task automatic test_sw();
        row_t t[5];
        t = '{'{4'd3, 1'b0, 1'b1, c_f_ack}, '{4'd3, 1'b0, 1'b0, c_dec},
              '{4'd2, 1'b0, 1'b0, c_ex_imm}, '{4'd2, 1'b0, 1'b1, c_mem_st},
              '{4'd3, 1'b0, 1'b0, c_f_wait}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL sw[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 4) @(negedge clk);
        end
    endtask

    // BEQ taken then not taken, back to back
    task automatic test_beq();
        row_t t[7];
        t = '{'{4'd4, 1'b1, 1'b1, c_f_ack}, '{4'd4, 1'b1, 1'b0, c_dec},
              '{4'd4, 1'b1, 1'b0, c_ex_beq_t}, '{4'd4, 1'b0, 1'b1, c_f_ack},
              '{4'd4, 1'b0, 1'b0, c_dec}, '{4'd4, 1'b0, 1'b0, c_ex_beq_n},
              '{4'd4, 1'b0, 1'b0, c_f_wait}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL beq[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 6) @(negedge clk);
        end
    endtask

    // J then illegal opcode 9, each two cycles
    task automatic test_jump_illegal();
        row_t t[5];
        t = '{'{4'd5, 1'b0, 1'b1, c_f_ack}, '{4'd5, 1'b0, 1'b0, c_dec_j},
              '{4'd9, 1'b0, 1'b1, c_f_ack}, '{4'd9, 1'b0, 1'b0, c_dec},
              '{4'd0, 1'b0, 1'b0, c_f_wait}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL jump_illegal[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 4) @(negedge clk);
        end
    endtask

`ifdef CTRL_TIMEOUT_EN
    // Watchdog: no ack for 8 cycles faults; ack on cycle 8 proceeds normally
    task automatic test_watchdog();
        bus.opcode = 4'd9; bus.zero = 1'b0; bus.mem_ack = 1'b0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        for (int c = 1; c <= 10; c++) begin
            bus.mem_ack = (c == 10); #1;
            n_tests++;
            if (obs !== ((c <= 8) ? c_f_wait : c_fault)) begin
                n_fail++;
                $display("FAIL wd_expire[%0d]: got %h expected %h", c, obs, (c <= 8) ? c_f_wait : c_fault);
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
        for (int c = 1; c <= 9; c++) begin
            bus.mem_ack = (c == 8); #1;
            n_tests++;
            if (obs !== ((c < 8) ? c_f_wait : (c == 8) ? c_f_ack : c_dec)) begin
                n_fail++;
                $display("FAIL wd_late_ack[%0d]: got %h", c, obs);
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0; #1;
        n_tests++;
        if (obs !== c_f_wait) begin n_fail++; $display("FAIL wd_recover: got %h expected %h", obs, c_f_wait); end
    endtask
`else
    // Without the watchdog FETCH waits indefinitely and never faults
    task automatic test_watchdog();
        bus.opcode = 4'd9; bus.zero = 1'b0; bus.mem_ack = 1'b0;
        for (int c = 1; c <= 20; c++) @(negedge clk);
        #1;
        n_tests++;
        if (obs !== c_f_wait) begin n_fail++; $display("FAIL wd_none_wait: got %h expected %h", obs, c_f_wait); end
        bus.mem_ack = 1'b1; #1;
        n_tests++;
        if (obs !== c_f_ack) begin n_fail++; $display("FAIL wd_none_ack: got %h expected %h", obs, c_f_ack); end
        @(negedge clk); bus.mem_ack = 1'b0; #1;
        n_tests++;
        if (obs !== c_dec) begin n_fail++; $display("FAIL wd_none_dec: got %h expected %h", obs, c_dec); end
        @(negedge clk); #1;
        n_tests++;
        if (obs !== c_f_wait) begin n_fail++; $display("FAIL wd_none_back: got %h expected %h", obs, c_f_wait); end
    endtask
`endif

    // Asynchronous reset in the middle of an SW memory access
    task automatic test_reset_mid();
        row_t t[4];
        t = '{'{4'd3, 1'b0, 1'b1, c_f_ack}, '{4'd3, 1'b0, 1'b0, c_dec},
              '{4'd3, 1'b0, 1'b0, c_ex_imm}, '{4'd3, 1'b0, 1'b0, c_mem_st}};
        foreach (t[i]) begin
            bus.opcode = t[i].op; bus.zero = t[i].z; bus.mem_ack = t[i].ack; #1;
            n_tests++;
            if (obs !== t[i].e) begin n_fail++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, obs, t[i].e); end
            if (i != 3) @(negedge clk);
        end
        #1 rst_n = 1'b0; #1;
        n_tests++;
        if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_mid_drop: got %h expected %h", obs, 16'h0); end
        @(negedge clk); #1;
        n_tests++;
        if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_mid_hold: got %h expected %h", obs, 16'h0); end
        rst_n = 1'b1; #1;
        n_tests++;
        if (obs !== 16'h0) begin n_fail++; $display("FAIL reset_mid_idle: got %h expected %h", obs, 16'h0); end
        @(negedge clk); #1;
        n_tests++;
        if (obs !== c_f_wait) begin n_fail++; $display("FAIL reset_mid_refetch: got %h expected %h", obs, c_f_wait); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_wait();
        test_sw();
        test_beq();
        test_jump_illegal();
        test_watchdog();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run can never hang
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
`default_nettype wire
